// File: rtl/outstream_check_if.sv
// Word-stream handshake between a stream source and the receiver.
// The source drives write/data; the receiver answers with rready.
interface outstream_check_if #(
    parameter int WIDTH = 11
);
    logic             write;
    logic [WIDTH-1:0] data;
    logic             rready;

    modport master (
        output write,
        output data,
        input  rready
    );

    modport slave (
        input  write,
        input  data,
        output rready
    );
endinterface

// File: rtl/outstream_check.sv
// Stream receiver: captures words in order, checks them against an
// expected table, and reports done/pass/first-mismatch/overflow.
module outstream_check #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         stall_i,
    input  logic [5:0]                   length_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]  expected_i,
    outstream_check_if.slave             s,
    input  logic [5:0]                   rd_addr_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [6:0]                   count_o,
    output logic                         done_o,
    output logic                         pass_o,
    output logic                         mismatch_o,
    output logic [5:0]                   err_idx_o,
    output logic                         overflow_o
);

    typedef enum logic {
        RECV = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       count_q, count_d;
    logic             rready_q, rready_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch_q, mismatch_d;
    logic [5:0]       err_idx_q, err_idx_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             xfer;

    // rready is only ever high in RECV, so this is the whole transfer rule.
    assign xfer = s.write && rready_q;

    // Next-state and next-output computation for the receive FSM.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = done_q;
        pass_d     = pass_q;
        mismatch_d = mismatch_q;
        err_idx_d  = err_idx_q;
        overflow_d = overflow_q;
        rready_d   = 1'b0;
        unique case (state_q)
            RECV: begin
                if (xfer) begin
                    count_d = count_q + 7'd1;
                    if (s.data != expected_i[count_q[5:0]] && !mismatch_q) begin
                        mismatch_d = 1'b1;
                        err_idx_d  = count_q[5:0];
                    end
                end
                if (count_d == {1'b0, length_i}) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = !mismatch_d;
                end
                rready_d = !stall_i && (count_d < {1'b0, length_i});
            end
            DONE: begin
                if (s.write) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = RECV;
        endcase
    end

    // State and registered outputs; clear behaves like a clocked reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RECV;
            count_q    <= '0;
            rready_q   <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            state_q    <= RECV;
            count_q    <= '0;
            rready_q   <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rready_q   <= rready_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            mismatch_q <= mismatch_d;
            err_idx_q  <= err_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Capture memory keeps its contents across reset; clear blocks the write.
    always_ff @(posedge clk) begin
        if (xfer && !clear_i && !rst) begin
            mem_q[count_q[5:0]] <= s.data;
        end
    end

    assign s.rready   = rready_q;
    assign rd_data_o  = mem_q[rd_addr_i];
    assign count_o    = count_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign mismatch_o = mismatch_q;
    assign err_idx_o  = err_idx_q;
    assign overflow_o = overflow_q;

endmodule
